// File: rtl/cpu_nbit.sv
// cpu_nbit: parametrised multicycle CPU core (FETCH/DECODE/EXEC/WB/HALT) with a valid/request fetch handshake.
// Optional feature macro CPU_CARRY_EN: carry flag, ADC and JC; without it opcodes C/D decode as NOP.
module cpu_nbit #(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 8,
  parameter  int NREGS   = 4,
  localparam int RIDX_W  = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2*RIDX_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_req,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               halted,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               dbg_we,
  output logic [RIDX_W-1:0]  dbg_waddr,
  output logic [DATA_W-1:0]  dbg_wdata
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_ADC  = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  a, b;
  logic [DATA_W-1:0]  regs [NREGS];
  logic               z_q;

  logic [3:0]         op;
  logic [RIDX_W-1:0]  rd, rs;
  logic [DATA_W-1:0]  imm;

  assign op  = ir[INSTR_W-1 -: 4];
  assign rd  = ir[INSTR_W-5 -: RIDX_W];
  assign rs  = ir[INSTR_W-5-RIDX_W -: RIDX_W];
  assign imm = ir[DATA_W-1:0];

`ifdef CPU_CARRY_EN
  localparam int SUM_W = DATA_W + 1;
  logic c_q, alu_c;
`else
  localparam int SUM_W = DATA_W;
`endif

  // One shared adder serves ADD, ADDI and ADC.
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W-1:0] alu_y;
  logic              wr_en, fl_en, take;

  assign add_b = (op == OP_ADDI) ? imm : b;
`ifdef CPU_CARRY_EN
  assign add_cin = (op == OP_ADC) & c_q;
`else
  assign add_cin = 1'b0;
`endif
  assign sum = SUM_W'(a) + SUM_W'(add_b) + SUM_W'(add_cin);

  always_comb begin
    alu_y = '0;
    wr_en = 1'b0;
    fl_en = 1'b0;
    take  = 1'b0;
    case (op)
      OP_LDI:  begin alu_y = imm;                wr_en = 1'b1; end
      OP_ADD:  begin alu_y = sum[DATA_W-1:0];    wr_en = 1'b1; fl_en = 1'b1; end
      OP_SUB:  begin alu_y = a - b;              wr_en = 1'b1; fl_en = 1'b1; end
      OP_AND:  begin alu_y = a & b;              wr_en = 1'b1; fl_en = 1'b1; end
      OP_OR:   begin alu_y = a | b;              wr_en = 1'b1; fl_en = 1'b1; end
      OP_XOR:  begin alu_y = a ^ b;              wr_en = 1'b1; fl_en = 1'b1; end
      OP_MOV:  begin alu_y = b;                  wr_en = 1'b1; end
      OP_ADDI: begin alu_y = sum[DATA_W-1:0];    wr_en = 1'b1; fl_en = 1'b1; end
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = z_q;
      OP_JNZ:  take = ~z_q;
`ifdef CPU_CARRY_EN
      OP_ADC:  begin alu_y = sum[DATA_W-1:0];    wr_en = 1'b1; fl_en = 1'b1; end
      OP_JC:   take = c_q;
`endif
      default: ;
    endcase
  end

`ifdef CPU_CARRY_EN
  always_comb begin
    case (op)
      OP_ADD, OP_ADDI, OP_ADC: alu_c = sum[DATA_W];
      OP_SUB:                  alu_c = (a < b);
      default:                 alu_c = 1'b0;
    endcase
  end
  assign carry_flag = c_q;
`else
  assign carry_flag = 1'b0;
`endif

  assign instr_req  = reset && (state == S_FETCH);
  assign instr_addr = pc;
  assign halted     = (state == S_HALT);
  assign zero_flag  = z_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      z_q       <= 1'b0;
      regs      <= '{default: '0};
      dbg_we    <= 1'b0;
      dbg_waddr <= '0;
      dbg_wdata <= '0;
`ifdef CPU_CARRY_EN
      c_q       <= 1'b0;
`endif
    end else begin
      dbg_we <= 1'b0;
      case (state)
        S_FETCH: if (instr_valid) begin
          ir    <= instr;
          pc    <= pc + ADDR_W'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          a     <= regs[rd];
          b     <= regs[rs];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (op == OP_HALT) begin
            state <= S_HALT;
          end else if (take) begin
            pc    <= imm[ADDR_W-1:0];
            state <= S_FETCH;
          end else if (wr_en) begin
            // dbg_wdata doubles as the latched result; flags show in the WB cycle with it
            dbg_we    <= 1'b1;
            dbg_waddr <= rd;
            dbg_wdata <= alu_y;
            if (fl_en) begin
              z_q <= (alu_y == '0);
`ifdef CPU_CARRY_EN
              c_q <= alu_c;
`endif
            end
            state <= S_WB;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB: begin
          regs[dbg_waddr] <= dbg_wdata;
          state           <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
